// File: rtl/mux_nx1_pkg.sv
// Shared constants and helpers for the N-to-1 registered mux with round-robin arbitration.
package mux_nx1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Next channel index, wrapping at n (not at the next power of two).
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the search starts just after the last granted channel.
module rr_arbiter
    import mux_nx1_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic [SEL_W-1:0] gnt_in,
    output logic [SEL_W-1:0] gnt,
    output logic             gnt_vld
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] idx;

    // Pointer remembers the last granted channel; reset to N-1 so channel 0 is searched first.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            ptr_q <= SEL_W'(N - 1);
        end else if (advance) begin
            ptr_q <= gnt_in;
        end
    end

    // Scan ptr+1, ptr+2, ... modulo N; the first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = ptr_q;
        for (int unsigned k = 0; k < N; k++) begin
            idx = SEL_W'(next_idx(32'(idx), N));
            if (!gnt_vld && req[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel registered mux with valid/ready handshakes; fixed-select or round-robin mode.
module mux_nx1_rr
    import mux_nx1_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic               clock,
    input  logic               reset_b,
    input  logic               mode,
    input  logic [SEL_W-1:0]   select,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   m_out,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [SEL_W-1:0]   m_chan
);

    logic             accept;
    logic             fix_vld;
    logic [SEL_W-1:0] rr_gnt;
    logic             rr_vld;
    logic [SEL_W-1:0] gnt;
    logic             gnt_vld;
    logic             advance;
    logic [WIDTH-1:0] gnt_data;

    // Output register is free, or its beat leaves this cycle.
    assign accept = !m_valid || m_ready;

    // Out-of-range select (non-power-of-two N) never grants.
    assign fix_vld = (32'(select) < N) && in_valid[select];

    // Pointer only moves on a real round-robin transfer.
    assign advance = accept && rr_vld && (mode == MODE_RR);

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .clock   (clock),
        .reset_b (reset_b),
        .req     (in_valid),
        .advance (advance),
        .gnt_in  (rr_gnt),
        .gnt     (rr_gnt),
        .gnt_vld (rr_vld)
    );

    // Pick the grant source for the current mode.
    always_comb begin
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_vld = rr_vld;
        end else begin
            gnt     = select;
            gnt_vld = fix_vld;
        end
    end

    assign gnt_data = in_data[32'(gnt) * WIDTH +: WIDTH];

    // One-hot ready toward the granted channel, only when the output can take a beat.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = accept && gnt_vld && (32'(gnt) == i);
        end
    end

    // Output stage: load on grant, drain when idle, hold under backpressure.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            m_out   <= '0;
            m_valid <= 1'b0;
            m_chan  <= '0;
        end else if (accept) begin
            if (gnt_vld) begin
                m_out   <= gnt_data;
                m_chan  <= gnt;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: directed cases plus randomized traffic against a model.
module tb_mux_nx1_rr;

    logic        clock;
    logic        reset_b;

    // N=4, WIDTH=8 instance
    logic        mode;
    logic [1:0]  select;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  m_out;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_chan;

    // N=3, WIDTH=8 instance
    logic        b_mode;
    logic [1:0]  b_select;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [7:0]  b_m_out;
    logic        b_m_valid;
    logic        b_m_ready;
    logic [1:0]  b_m_chan;

    int checks = 0;
    int errors = 0;

    // Reference model state for the N=4 instance
    bit       e_valid;
    bit [7:0] e_out;
    int       e_chan;
    int       last;

    mux_nx1_rr #(.WIDTH(8), .N(4)) dut (
        .clock    (clock),
        .reset_b  (reset_b),
        .mode     (mode),
        .select   (select),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .m_out    (m_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_chan   (m_chan)
    );

    mux_nx1_rr #(.WIDTH(8), .N(3)) dut3 (
        .clock    (clock),
        .reset_b  (reset_b),
        .mode     (b_mode),
        .select   (b_select),
        .in_data  (b_in_data),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .m_out    (b_m_out),
        .m_valid  (b_m_valid),
        .m_ready  (b_m_ready),
        .m_chan   (b_m_chan)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 0;
        e_out   = 8'h00;
        e_chan  = 0;
        last    = 3;
    endtask

    // Grant from the rules: fixed mode takes select if it requests; round-robin takes the
    // first requester after the last granted channel, counting modulo 4.
    task automatic model_grant(output int g, output bit gv);
        g  = 0;
        gv = 0;
        if (mode == 1'b0) begin
            g  = int'(select);
            gv = in_valid[g];
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (!gv && in_valid[(last + k) % 4]) begin
                    g  = (last + k) % 4;
                    gv = 1;
                end
            end
        end
    endtask

    // One clock of the N=4 instance: check ready before the edge, outputs after it.
    task automatic cyc4(input string tag);
        int       g;
        bit       gv;
        bit       acc;
        bit [3:0] er;
        #1;
        model_grant(g, gv);
        acc = !e_valid || m_ready;
        er  = 4'b0000;
        if (acc && gv) er[g] = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clock);
        if (acc && gv) begin
            e_valid = 1;
            e_out   = in_data[g*8 +: 8];
            e_chan  = g;
            if (mode == 1'b1) last = g;
        end else if (acc) begin
            e_valid = 0;
        end
        #1;
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(e_valid));
        chk({tag, ".m_out"},   32'(m_out),   32'(e_out));
        chk({tag, ".m_chan"},  32'(m_chan),  32'(e_chan));
    endtask

    initial begin
        clock      = 0;
        reset_b    = 0;
        mode       = 0;
        select     = 0;
        in_data    = 0;
        in_valid   = 0;
        m_ready    = 1;
        b_mode     = 0;
        b_select   = 0;
        b_in_data  = 0;
        b_in_valid = 0;
        b_m_ready  = 1;
        model_reset();

        // Reset state
        #3;
        chk("rst.m_valid", 32'(m_valid), 32'd0);
        chk("rst.m_out",   32'(m_out),   32'd0);
        chk("rst.m_chan",  32'(m_chan),  32'd0);
        #4 reset_b = 1;

        // Fixed mode, select=2
        mode = 0; select = 2; in_data = 32'h003C_0000; in_valid = 4'b0100; m_ready = 1;
        cyc4("fix2");
        chk("fix2.data", 32'(m_out), 32'h3C);
        // select=1 while ch1 idle: no grant, drains
        select = 1;
        cyc4("fix1_idle");
        chk("fix1_idle.valid", 32'(m_valid), 32'd0);

        // Round-robin fairness, all requesting
        mode = 1; in_valid = 4'b1111; in_data = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            cyc4("rr_all");
            chk("rr_all.seq", 32'(m_chan), 32'(k % 4));
            chk("rr_all.dat", 32'(m_out), 32'(8'h10 + (k % 4)));
        end

        // Reset mid-stream with a held beat
        mode = 0; select = 0; in_data = 32'h0000_00A5; in_valid = 4'b0001;
        cyc4("pre_rst");
        chk("pre_rst.out", 32'(m_out), 32'hA5);
        #2 reset_b = 0;
        #1;
        chk("midrst.m_valid", 32'(m_valid), 32'd0);
        chk("midrst.m_out",   32'(m_out),   32'd0);
        chk("midrst.m_chan",  32'(m_chan),  32'd0);
        model_reset();
        #1 reset_b = 1;

        // Backpressure after the first beat
        mode = 1; in_valid = 4'b0011; in_data = 32'h0000_2120; m_ready = 1;
        cyc4("bp_first");
        chk("bp_first.chan", 32'(m_chan), 32'd0);
        m_ready = 0;
        for (int k = 0; k < 3; k++) begin
            cyc4("bp_hold");
            chk("bp_hold.out", 32'(m_out), 32'h20);
        end
        m_ready = 1;
        cyc4("bp_release");
        chk("bp_release.chan", 32'(m_chan), 32'd1);
        chk("bp_release.out",  32'(m_out),  32'h21);
        in_valid = 4'b0000;
        cyc4("bp_drain");

        // Wrap and skip
        in_data = 32'h4342_4140;
        in_valid = 4'b1000; cyc4("wrap_ch3");
        in_valid = 4'b0100; cyc4("wrap_ch2");
        chk("wrap_ch2.chan", 32'(m_chan), 32'd2);
        in_valid = 4'b1001; cyc4("skip_ch3");
        chk("skip_ch3.chan", 32'(m_chan), 32'd3);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            mode     = 1'($urandom_range(0, 1));
            select   = 2'($urandom_range(0, 3));
            in_data  = $urandom;
            in_valid = 4'($urandom_range(0, 15));
            m_ready  = ($urandom_range(0, 3) != 0);
            cyc4("rand");
        end
        in_valid = 4'b0000;

        // N=3 instance: out-of-range select never grants
        b_mode = 0; b_select = 2'b11; b_in_valid = 3'b111; b_in_data = 24'h32_3130;
        b_m_ready = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("n3_fix.in_ready", 32'(b_in_ready), 32'd0);
            @(posedge clock); #1;
            chk("n3_fix.m_valid", 32'(b_m_valid), 32'd0);
        end
        // Round-robin wraps at 3
        b_mode = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            chk("n3_rr.valid", 32'(b_m_valid), 32'd1);
            chk("n3_rr.chan",  32'(b_m_chan),  32'(k % 3));
            chk("n3_rr.out",   32'(b_m_out),   32'(8'h30 + (k % 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
